// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmitter and the future receiver:
// frame state encoding, parity selection codes and a constant clog2.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clog2(input longint value);
        int result;
        result = 0;
        while ((longint'(1) << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Fractional bit-rate generator: adds BAUD_RATE per cycle modulo CLOCK_FREQ and
// ticks on each wrap, so bit boundaries never accumulate rounding error.
module rs232_baud_gen
    import rs232_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    // One extra bit so acc + BAUD_RATE (< 2*CLOCK_FREQ) never overflows.
    localparam int ACC_W = clog2(CLOCK_FREQ) + 1;
    localparam logic [ACC_W-1:0] INC = ACC_W'(BAUD_RATE);
    localparam logic [ACC_W-1:0] MOD = ACC_W'(CLOCK_FREQ);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sum;

    // tick deliberately ignores clear: the caller decides to clear based on tick.
    always_comb begin
        sum      = acc_reg + INC;
        tick     = (sum >= MOD);
        acc_next = tick ? (sum - MOD) : sum;
        if (clear) begin
            acc_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/rs232_send_fifo.sv
// Buffered RS232 transmitter with configurable frame and RTS flow control at frame boundaries.
// The parity stage is compiled in only when RS232_SEND_PARITY_EN is defined.
module rs232_send_fifo
    import rs232_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int DEPTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 rs232_rxd,
    input  logic                 rs232_rts_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

`ifdef RS232_SEND_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif
    localparam bit HAS_PARITY = PARITY_BUILT && (PARITY != PARITY_NONE);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic                 ready_reg;
    logic                 push, pop, empty, full_next;
    logic [DATA_BITS-1:0] fifo_head;

    logic                 rts_meta_reg, rts_sync_reg;
    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           cnt_reg, cnt_next;
    logic                 rxd_reg, rxd_next;
    logic                 tick, baud_clear, start_ok;
`ifdef RS232_SEND_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign push        = valid && ready_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign wr_ptr_next = wr_ptr_reg + PW'(push);
    assign rd_ptr_next = rd_ptr_reg + PW'(pop);
    assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                         (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    assign fifo_head   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ready_reg    <= 1'b0;
            rts_meta_reg <= 1'b1;
            rts_sync_reg <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            ready_reg    <= !full_next;
            rts_meta_reg <= rs232_rts_n;
            rts_sync_reg <= rts_meta_reg;
        end
    end

    assign start_ok   = !empty && !rts_sync_reg;
    assign baud_clear = (state_reg == ST_IDLE) || pop;

    rs232_baud_gen #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud_gen (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        rxd_next   = 1'b1;
`ifdef RS232_SEND_PARITY_EN
        parity_next = parity_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    pop = 1'b1;
                end
            end
            ST_START: begin
                rxd_next = 1'b0;
                if (tick) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                rxd_next = shift_reg[0];
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (cnt_reg == 3'(DATA_BITS - 1)) begin
                        state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
`ifdef RS232_SEND_PARITY_EN
            ST_PARITY: begin
                rxd_next = parity_reg;
                if (tick) begin
                    state_next = ST_STOP;
                    cnt_next   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (cnt_reg == 3'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when allowed: no idle bit.
                        state_next = ST_IDLE;
                        pop        = start_ok;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (pop) begin
            state_next = ST_START;
            shift_next = fifo_head;
            cnt_next   = '0;
`ifdef RS232_SEND_PARITY_EN
            parity_next = (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
`endif
        end
    end

    // The line is registered, so it trails the state by one cycle throughout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            rxd_reg   <= 1'b1;
`ifdef RS232_SEND_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            rxd_reg   <= rxd_next;
`ifdef RS232_SEND_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign rs232_rxd = rxd_reg;
    assign ready     = ready_reg;
    assign busy      = (state_reg != ST_IDLE) || !empty;

endmodule

// File: doc/rs232_send_fifo.md
# rs232_send_fifo

Parametrised successor to the single-byte RS232 transmitter, sitting between on-chip producers and the board UART pin. It buffers words in a small FIFO and generates bit timing with a fractional accumulator, so bit boundaries never drift for any CLOCK_FREQ/BAUD_RATE ratio. Frame format is configurable: data bits, stop bits and optional parity. It honours hardware flow control on rs232_rts_n, applied at frame boundaries.

## Interface
- CLOCK_FREQ, 133000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s; must be < CLOCK_FREQ/2.
- DATA_BITS, 8: payload bits per frame, 5..8, sent LSB first.
- STOP_BITS, 1: stop bits, 1 or 2.
- PARITY, 0: 0 none, 1 odd, 2 even (used only with RS232_SEND_PARITY_EN).
- DEPTH, 16: FIFO words, power of two, ≥2.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- rs232_rxd  out  1  serial line; idle high.
- rs232_rts_n  in  1  peer flow control; low = may send. Asynchronous, double-flop synchronised inside.
- data  in  DATA_BITS  word to send.
- valid  in  1  producer has a word.
- ready  out  1  FIFO not full; registered.
- busy  out  1  frame in progress or FIFO non-empty.

## Operation
- Write handshake: the word is accepted on a rising edge where valid && ready.
- valid with ready low: no effect; the producer holds data.
- FIFO: DEPTH entries, wrapping pointers of width clog2(DEPTH)+1 (extra MSB separates full from empty).
- ready = !full. It drops in the cycle the last free slot is written. It rises on the edge after a pop from full.
- Baud accumulator: width clog2(CLOCK_FREQ)+1.
  - Cleared at frame start.
  - Each cycle: if acc+BAUD_RATE ≥ CLOCK_FREQ, then tick=1 and acc ← acc+BAUD_RATE−CLOCK_FREQ; else acc ← acc+BAUD_RATE.
  - A tick ends the current bit. Bit length is ⌊C/B⌋ or ⌈C/B⌉ cycles, with no cumulative error.
- State machine:
  - IDLE: leave when FIFO non-empty and synchronised rts_n low. Then pop into the shift register and go to START.
  - START: line 0 for 1 bit.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: 1 bit, only when compiled in and PARITY≠0.
  - STOP: line 1 for STOP_BITS bits, then IDLE.
- Flow control is sampled only in IDLE. A frame in progress always completes even if rts_n rises.
- Back-to-back frames: when STOP ends, IDLE starts the next frame in the same cycle if its condition holds. No extra idle bit is inserted.
- FIFO push and pop in the same cycle: both occur, including when full (ready is already low, so no push) or when empty (no pop).
- Reset values: rs232_rxd=1, ready=0, busy=0. FIFO empty, state IDLE, accumulator 0, synchroniser flops 1.
- Reset mid-frame: line returns to 1 immediately (asynchronously). Buffered words are discarded.

## Timing
- ready rises on the first edge after reset deasserts.
- Latency: word accepted at edge N into an empty FIFO, with rts_n already low ≥2 cycles. The start bit drives rs232_rxd from edge N+2 (one cycle for the FIFO write, one for the pop/start).
- rts_n latency: 2 flops. A falling rts_n can start a frame from the 3rd edge after the fall.
- Frame length in bits: 1 + DATA_BITS + (parity?1:0) + STOP_BITS. Length in cycles is that bit count times C/B on average, within ±1 cycle.
- busy falls on the edge the last stop bit ends with the FIFO empty.

## Configuration
- RS232_SEND_PARITY_EN defined:
  - PARITY is honoured.
  - Odd: the parity bit makes the count of ones in data+parity odd. Even: that count is even.
- RS232_SEND_PARITY_EN undefined:
  - No PARITY state or parity logic is synthesised and PARITY is ignored.
  - Frames are always 8N1-style: no parity bit.

## Structure
- Package rs232_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity encoding constants (PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2);
  - clog2 function, shared with the future receiver.
- Sub-module rs232_baud_gen: accumulator, clear input, tick output. It is reused by the receiver (which clears at half-bit offset).
- FIFO stays inline; it is too small to warrant a module.

## Test plan
- CLOCK_FREQ=10, BAUD_RATE=3, DATA_BITS=8, STOP_BITS=1, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1. Any 3 consecutive bits span exactly 10 cycles; each bit lasts 3 or 4 cycles.
- DEPTH=4, rts_n high, push 5 words -> ready low after the 4th accept, 5th held. Lower rts_n -> 4 frames back-to-back with no idle gap, then the 5th word, then busy low.
- Raise rts_n mid-frame of word 0xA3 -> frame completes, next frame does not start until rts_n has been low 2 cycles.
- Parity enabled, PARITY=2, DATA_BITS=7, send 0x07 -> parity bit 1. PARITY=1 -> parity bit 0. Macro undefined -> no parity bit, frame 9 bits.
- STOP_BITS=2, DATA_BITS=5, send 0x1F -> 8-bit frame, line high for 2 bit periods before the next start bit.
- Assert reset during bit 3 with 2 words queued -> rs232_rxd=1 immediately, ready=0. After release: ready=1 next edge, busy=0, no frame is transmitted.
